hazard_unit_fwd: RTL and testbench

Parametrised next-generation hazard unit for the 16-bit pipelined core. It sits beside the IF/ID/EX/MEM/WB pipeline registers. It generates EX-stage forwarding selects, load-use and branch-operand stalls, and bubble/flush controls. It also holds a BHT of 2-bit saturating counters with a mispredict counter. With FWD_EN=0 it reverts to stall-on-any-dependency operation.

---
 rtl/hazard_unit_fwd.sv | 167 ++++++++++++++++
 tb/tb_hazard_unit_fwd.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_fwd.sv
// Hazard unit for the 16-bit pipelined core: EX forwarding selects, load-use and
// branch-operand stalls, mispredict flush, and a 2-bit BHT with a mispredict counter.
module hazard_unit_fwd #(
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned OP_W      = 3,
    parameter int unsigned REG_W     = 3,
    parameter int unsigned BHT_IDX_W = 3,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned FWD_EN    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] ifid_instr,
    input  logic [15:0]        ifid_pc,
    input  logic [INSTR_W-1:0] idex_instr,
    input  logic               idex_write,
    input  logic               idex_regdst,
    input  logic               idex_memread,
    input  logic [INSTR_W-1:0] exmem_instr,
    input  logic               exmem_write,
    input  logic               exmem_regdst,
    input  logic               exmem_memread,
    input  logic [REG_W-1:0]   memwb_dest,
    input  logic               memwb_write,
    input  logic               ex_br_valid,
    input  logic               ex_br_taken,
    input  logic               ex_br_pred,
    input  logic [15:0]        ex_br_pc,
    output logic               pc_stall,
    output logic               ifid_stall,
    output logic               idex_bubble,
    output logic               flush,
    output logic               predict_taken,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic [CNT_W-1:0]   mispredict_count
);

    localparam int unsigned RS_LSB = INSTR_W - OP_W - REG_W;
    localparam int unsigned RT_LSB = RS_LSB - REG_W;
    localparam int unsigned RD_LSB = RT_LSB - REG_W;
    localparam int unsigned BHT_N  = 2 ** BHT_IDX_W;
    localparam logic [OP_W-1:0] OP_R   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(6);

    function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] i);
        return i[INSTR_W-1 -: OP_W];
    endfunction

    function automatic logic [REG_W-1:0] rs_of(input logic [INSTR_W-1:0] i);
        return i[RS_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rt_of(input logic [INSTR_W-1:0] i);
        return i[RT_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rd_of(input logic [INSTR_W-1:0] i);
        return i[RD_LSB +: REG_W];
    endfunction

    function automatic logic reads_rt(input logic [INSTR_W-1:0] i);
        return (op_of(i) == OP_R) || (op_of(i) == OP_BEQ) || (op_of(i) == OP_SW);
    endfunction

    // Register 0 is hardwired and never creates a dependency.
    function automatic logic hit_a(input logic [INSTR_W-1:0] i, input logic [REG_W-1:0] d,
                                   input logic wr);
        return wr && (rs_of(i) != '0) && (rs_of(i) == d);
    endfunction

    function automatic logic hit_b(input logic [INSTR_W-1:0] i, input logic [REG_W-1:0] d,
                                   input logic wr);
        return wr && reads_rt(i) && (rt_of(i) != '0) && (rt_of(i) == d);
    endfunction

    logic [REG_W-1:0] ex_dest, mem_dest;
    logic             id_hits_ex, id_hits_mem, id_is_beq;
    logic             stall_cond, mispredict;
    logic [1:0]       fwd_a, fwd_b;
    logic [1:0]       bht [BHT_N];
    logic             unused_bits;

    assign ex_dest     = idex_regdst  ? rd_of(idex_instr)  : rt_of(idex_instr);
    assign mem_dest    = exmem_regdst ? rd_of(exmem_instr) : rt_of(exmem_instr);
    assign id_is_beq   = (op_of(ifid_instr) == OP_BEQ);
    assign id_hits_ex  = hit_a(ifid_instr, ex_dest, idex_write)
                       | hit_b(ifid_instr, ex_dest, idex_write);
    assign id_hits_mem = hit_a(ifid_instr, mem_dest, exmem_write)
                       | hit_b(ifid_instr, mem_dest, exmem_write);
    assign mispredict  = ex_br_valid && (ex_br_taken != ex_br_pred);
    assign unused_bits = ^{ifid_instr, ifid_pc, idex_instr, exmem_instr, ex_br_pc};

    always_comb begin
        stall_cond = 1'b0;
        if (FWD_EN != 0) begin
            stall_cond = (idex_memread && id_hits_ex)
                       || (id_is_beq && id_hits_ex)
                       || (id_is_beq && exmem_memread && id_hits_mem);
        end else begin
            stall_cond = id_hits_ex || id_hits_mem;
        end
    end

    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (FWD_EN != 0) begin
            if (hit_a(idex_instr, mem_dest, exmem_write))
                fwd_a = 2'd1;
            else if (hit_a(idex_instr, memwb_dest, memwb_write))
                fwd_a = 2'd2;
            if (hit_b(idex_instr, mem_dest, exmem_write))
                fwd_b = 2'd1;
            else if (hit_b(idex_instr, memwb_dest, memwb_write))
                fwd_b = 2'd2;
        end
    end

    always_comb begin
        pc_stall      = 1'b0;
        ifid_stall    = 1'b0;
        idex_bubble   = 1'b0;
        flush         = 1'b0;
        predict_taken = 1'b0;
        fwd_a_sel     = 2'd0;
        fwd_b_sel     = 2'd0;
        if (reset) begin
            pc_stall    = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            fwd_a_sel     = fwd_a;
            fwd_b_sel     = fwd_b;
            predict_taken = id_is_beq && bht[ifid_pc[BHT_IDX_W-1:0]][1];
            // A mispredict squashes the stalled instruction, so the stall is moot.
            if (mispredict) begin
                flush       = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall_cond) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_N; i++)
                bht[i] <= 2'd1;
        end else if (ex_br_valid) begin
            if (ex_br_taken && bht[ex_br_pc[BHT_IDX_W-1:0]] != 2'd3)
                bht[ex_br_pc[BHT_IDX_W-1:0]] <= bht[ex_br_pc[BHT_IDX_W-1:0]] + 2'd1;
            else if (!ex_br_taken && bht[ex_br_pc[BHT_IDX_W-1:0]] != 2'd0)
                bht[ex_br_pc[BHT_IDX_W-1:0]] <= bht[ex_br_pc[BHT_IDX_W-1:0]] - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            mispredict_count <= '0;
        else if (flush && mispredict_count != '1)
            mispredict_count <= mispredict_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_unit_fwd.sv
// Scoreboard bench for hazard_unit_fwd: one forwarding instance and one stall-only
// instance share stimulus; expected outputs are queued and checked on the falling edge.
module tb_hazard_unit_fwd;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] ifid_instr, ifid_pc, idex_instr, exmem_instr, ex_br_pc;
    logic        idex_write, idex_regdst, idex_memread;
    logic        exmem_write, exmem_regdst, exmem_memread;
    logic [2:0]  memwb_dest;
    logic        memwb_write, ex_br_valid, ex_br_taken, ex_br_pred;

    logic       ps1, is1, ib1, fl1, pr1;
    logic [1:0] fa1, fb1;
    logic [7:0] cnt1;
    logic       ps0, is0, ib0, fl0, pr0;
    logic [1:0] fa0, fb0;
    logic [7:0] cnt0;

    typedef struct {
        int         vec;
        logic       ps, is, ib, fl, pr;
        logic [1:0] fa, fb;
        logic [7:0] cnt;
        logic       ps0, is0, ib0;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec   = 0;

    always #5 clock = ~clock;

    hazard_unit_fwd u_fwd (
        .clock(clock), .reset(reset), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .idex_instr(idex_instr), .idex_write(idex_write), .idex_regdst(idex_regdst),
        .idex_memread(idex_memread), .exmem_instr(exmem_instr), .exmem_write(exmem_write),
        .exmem_regdst(exmem_regdst), .exmem_memread(exmem_memread), .memwb_dest(memwb_dest),
        .memwb_write(memwb_write), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
        .ex_br_pred(ex_br_pred), .ex_br_pc(ex_br_pc), .pc_stall(ps1), .ifid_stall(is1),
        .idex_bubble(ib1), .flush(fl1), .predict_taken(pr1), .fwd_a_sel(fa1),
        .fwd_b_sel(fb1), .mispredict_count(cnt1)
    );

    hazard_unit_fwd #(.FWD_EN(0)) u_nofwd (
        .clock(clock), .reset(reset), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .idex_instr(idex_instr), .idex_write(idex_write), .idex_regdst(idex_regdst),
        .idex_memread(idex_memread), .exmem_instr(exmem_instr), .exmem_write(exmem_write),
        .exmem_regdst(exmem_regdst), .exmem_memread(exmem_memread), .memwb_dest(memwb_dest),
        .memwb_write(memwb_write), .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
        .ex_br_pred(ex_br_pred), .ex_br_pc(ex_br_pc), .pc_stall(ps0), .ifid_stall(is0),
        .idex_bubble(ib0), .flush(fl0), .predict_taken(pr0), .fwd_a_sel(fa0),
        .fwd_b_sel(fb0), .mispredict_count(cnt0)
    );

    function automatic logic [15:0] mk(input int op, input int rs, input int rt, input int rd);
        return {op[2:0], rs[2:0], rt[2:0], rd[2:0], 4'b0000};
    endfunction

    task automatic clr();
        ifid_instr = '0; ifid_pc = '0; idex_instr = '0; exmem_instr = '0; ex_br_pc = '0;
        idex_write = 0; idex_regdst = 0; idex_memread = 0;
        exmem_write = 0; exmem_regdst = 0; exmem_memread = 0;
        memwb_dest = '0; memwb_write = 0;
        ex_br_valid = 0; ex_br_taken = 0; ex_br_pred = 0;
    endtask

    // st1/st0: raw stall condition for the forwarding / stall-only instance.
    task automatic push(input logic st1, input logic st0, input logic fl, input logic pr,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] cnt);
        exp_t e;
        e.vec = vec; e.cnt = cnt;
        if (reset) begin
            e.ps = 1; e.is = 0; e.ib = 1; e.fl = 0; e.pr = 0; e.fa = 0; e.fb = 0;
            e.ps0 = 1; e.is0 = 0; e.ib0 = 1;
        end else begin
            e.fl = fl; e.pr = pr; e.fa = fa; e.fb = fb;
            e.ps  = fl ? 1'b0 : st1; e.is  = fl ? 1'b0 : st1; e.ib  = fl | st1;
            e.ps0 = fl ? 1'b0 : st0; e.is0 = fl ? 1'b0 : st0; e.ib0 = fl | st0;
        end
        q.push_back(e);
        vec++;
    endtask

    task automatic chk(input string nm, input int v, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, v, act, want);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_stall", e.vec, 8'(ps1), 8'(e.ps));
            chk("ifid_stall", e.vec, 8'(is1), 8'(e.is));
            chk("idex_bubble", e.vec, 8'(ib1), 8'(e.ib));
            chk("flush", e.vec, 8'(fl1), 8'(e.fl));
            chk("predict", e.vec, 8'(pr1), 8'(e.pr));
            chk("fwd_a", e.vec, 8'(fa1), 8'(e.fa));
            chk("fwd_b", e.vec, 8'(fb1), 8'(e.fb));
            chk("mcount", e.vec, cnt1, e.cnt);
            chk("nofwd_pc_stall", e.vec, 8'(ps0), 8'(e.ps0));
            chk("nofwd_ifid_stall", e.vec, 8'(is0), 8'(e.is0));
            chk("nofwd_bubble", e.vec, 8'(ib0), 8'(e.ib0));
            chk("nofwd_fwd_a", e.vec, 8'(fa0), 8'd0);
            chk("nofwd_fwd_b", e.vec, 8'(fb0), 8'd0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        clr();
    endtask

    initial begin
        reset = 1;
        clr();
        // reset with a mispredicting branch present: no flush, no count, no BHT update
        step(); reset = 1;
        ex_br_valid = 1; ex_br_taken = 1; ex_br_pred = 0; ex_br_pc = 16'h0005;
        push(0, 0, 0, 0, 0, 0, 8'd0);
        step(); reset = 0;

        // add r3 in EX, add r1,r3 in ID
        idex_instr = mk(0, 1, 2, 3); idex_write = 1; idex_regdst = 1;
        ifid_instr = mk(0, 1, 3, 5);
        push(0, 1, 0, 0, 0, 0, 8'd0);
        // that instruction now in EX, the add r3 in MEM
        step();
        idex_instr = mk(0, 1, 3, 5); idex_write = 1; idex_regdst = 1;
        exmem_instr = mk(0, 1, 2, 3); exmem_write = 1; exmem_regdst = 1;
        push(0, 0, 0, 0, 2'd0, 2'd1, 8'd0);
        // load r2 in EX, ID reads r2
        step();
        idex_instr = mk(4, 1, 2, 0); idex_write = 1; idex_memread = 1;
        ifid_instr = mk(0, 2, 0, 0);
        push(1, 1, 0, 0, 0, 0, 8'd0);
        // bubble in EX, load now in MEM: stall released for forwarding build
        step();
        exmem_instr = mk(4, 1, 2, 0); exmem_write = 1; exmem_memread = 1;
        ifid_instr = mk(0, 2, 0, 0);
        push(0, 1, 0, 0, 0, 0, 8'd0);
        // load r2 in EX, ID reads rs=r0 (rt field r2 not read by op1)
        step();
        idex_instr = mk(4, 1, 2, 0); idex_write = 1; idex_memread = 1;
        ifid_instr = mk(1, 0, 2, 0);
        push(0, 0, 0, 0, 0, 0, 8'd0);
        // EXMEM and MEMWB both write r4, EX reads r4 twice
        step();
        idex_instr = mk(0, 4, 4, 0);
        exmem_instr = mk(0, 1, 1, 4); exmem_write = 1; exmem_regdst = 1;
        memwb_dest = 3'd4; memwb_write = 1;
        push(0, 0, 0, 0, 2'd1, 2'd1, 8'd0);
        // EXMEM not writing -> MEMWB; op3 does not read rt
        step();
        idex_instr = mk(3, 4, 4, 0);
        exmem_instr = mk(0, 1, 1, 4); exmem_regdst = 1;
        memwb_dest = 3'd4; memwb_write = 1;
        push(0, 0, 0, 0, 2'd2, 2'd0, 8'd0);
        // BEQ reads r1 produced by ALU op in EX
        step();
        idex_instr = mk(0, 1, 2, 1); idex_write = 1; idex_regdst = 1;
        ifid_instr = mk(2, 6, 1, 0);
        push(1, 1, 0, 0, 0, 0, 8'd0);
        // BEQ reads r6 loaded in MEM
        step();
        exmem_instr = mk(4, 0, 6, 0); exmem_write = 1; exmem_memread = 1;
        ifid_instr = mk(2, 6, 1, 0);
        push(1, 1, 0, 0, 0, 0, 8'd0);
        // non-branch reads r6 loaded in MEM
        step();
        exmem_instr = mk(4, 0, 6, 0); exmem_write = 1; exmem_memread = 1;
        ifid_instr = mk(0, 6, 0, 0);
        push(0, 1, 0, 0, 0, 0, 8'd0);
        // EXMEM writes r5, ID and EX read r5
        step();
        exmem_instr = mk(0, 0, 0, 5); exmem_write = 1; exmem_regdst = 1;
        idex_instr = mk(0, 5, 0, 0);
        ifid_instr = mk(1, 5, 0, 0);
        push(0, 1, 0, 0, 2'd1, 2'd0, 8'd0);

        // BHT: PC 5 taken three times, predictions read pre-update value
        for (int i = 0; i < 3; i++) begin
            step();
            ifid_instr = mk(2, 0, 0, 0); ifid_pc = 16'h0005;
            ex_br_valid = 1; ex_br_taken = 1; ex_br_pred = 1; ex_br_pc = 16'h0005;
            push(0, 0, 0, (i == 0) ? 1'b0 : 1'b1, 0, 0, 8'd0);
        end
        step();
        ifid_instr = mk(2, 0, 0, 0); ifid_pc = 16'h000D;
        push(0, 0, 0, 1, 0, 0, 8'd0);
        step();
        ifid_instr = mk(0, 0, 0, 0); ifid_pc = 16'h0005;
        push(0, 0, 0, 0, 0, 0, 8'd0);
        // aliased PC 0xD not taken four times: 3->2->1->0->0
        for (int i = 0; i < 4; i++) begin
            step();
            ifid_instr = mk(2, 0, 0, 0); ifid_pc = 16'h0005;
            ex_br_valid = 1; ex_br_taken = 0; ex_br_pred = 0; ex_br_pc = 16'h000D;
            push(0, 0, 0, (i < 2) ? 1'b1 : 1'b0, 0, 0, 8'd0);
        end

        // mispredict coinciding with a load-use stall
        step();
        idex_instr = mk(4, 1, 2, 0); idex_write = 1; idex_memread = 1;
        ifid_instr = mk(0, 2, 0, 0);
        ex_br_valid = 1; ex_br_taken = 1; ex_br_pred = 0; ex_br_pc = 16'h0020;
        push(1, 1, 1, 0, 0, 0, 8'd0);
        // drive the counter into saturation
        for (int i = 1; i <= 258; i++) begin
            step();
            ex_br_valid = 1; ex_br_taken = 1; ex_br_pred = 0; ex_br_pc = 16'h0020;
            push(0, 0, 1, 0, 0, 0, (i > 255) ? 8'd255 : 8'(i));
        end
        step();
        ex_br_valid = 1; ex_br_taken = 1; ex_br_pred = 1; ex_br_pc = 16'h0020;
        push(0, 0, 0, 0, 0, 0, 8'd255);

        // mid-run reset
        step(); reset = 1;
        ex_br_valid = 1; ex_br_taken = 1; ex_br_pred = 0; ex_br_pc = 16'h0020;
        push(0, 0, 0, 0, 0, 0, 8'd255);
        step(); reset = 1;
        push(0, 0, 0, 0, 0, 0, 8'd0);
        step(); reset = 0;
        ifid_instr = mk(2, 0, 0, 0); ifid_pc = 16'h0000;
        ex_br_valid = 1; ex_br_taken = 1; ex_br_pred = 1; ex_br_pc = 16'h0000;
        push(0, 0, 0, 0, 0, 0, 8'd0);
        step();
        ifid_instr = mk(2, 0, 0, 0); ifid_pc = 16'h0000;
        push(0, 0, 0, 1, 0, 0, 8'd0);

        for (int k = 0; k < 10 && q.size() != 0; k++) begin
            @(negedge clock);
            #1;
        end
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
